ad5543_driver: RTL



---
 rtl/ad5543_pkg.sv | 14 +
 rtl/ad5543_tick_gen.sv | 35 +++
 rtl/ad5543_driver.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/ad5543_pkg.sv
// Shared types and defaults for the AD5543 serial DAC driver.
package ad5543_pkg;

  localparam int AD5543_DW = 16;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOW  = 3'd1,
    ST_HIGH = 3'd2,
    ST_TAIL = 3'd3,
    ST_GAP  = 3'd4
  } ad5543_state_e;

endpackage

// File: rtl/ad5543_tick_gen.sv
// Phase timer for the AD5543 driver: counts CLK_DIV enabled cycles and pulses
// phase_done on the last one, then restarts from zero.
module ad5543_tick_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic phase_done
);

  localparam int CW = $clog2(CLK_DIV + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_r;

  assign phase_done = en && (cnt_r == CNT_LAST);

  // Phase counter, cleared on reset and on frame accept
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt_r <= {CW{1'b0}};
    end else if (en) begin
      if (cnt_r == CNT_LAST) begin
        cnt_r <= {CW{1'b0}};
      end else begin
        cnt_r <= cnt_r + CW'(1'b1);
      end
    end else begin
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: rtl/ad5543_driver.sv
// AD5543 serial DAC driver: one word per valid/ready handshake, shifted out MSB
// first on sdi/sclk under cs_n. Optional AD5543_DRV_SIGNED_EN converts din from
// two's complement to offset binary at accept.
module ad5543_driver
  import ad5543_pkg::*;
#(
  parameter int DW          = AD5543_DW,
  parameter int CLK_DIV     = 4,
  parameter int CS_HIGH_CYC = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] din,
  input  logic          din_valid,
  output logic          din_ready,
  output logic          sclk,
  output logic          sdi,
  output logic          cs_n,
  output logic          busy
);

  localparam int BW = $clog2(DW + 1);
  localparam int GW = $clog2(CS_HIGH_CYC + 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DW);
  localparam logic [GW-1:0] GAP_LAST = GW'(CS_HIGH_CYC - 1);

  ad5543_state_e state_r, state_s;
  logic [DW-2:0] shift_r, shift_s;
  logic [BW-1:0] bit_cnt_r, bit_cnt_s;
  logic [GW-1:0] gap_cnt_r, gap_cnt_s;
  logic          sclk_r, sclk_s;
  logic          sdi_r, sdi_s;
  logic          cs_n_r, cs_n_s;
  logic          ready_r, ready_s;
  logic          busy_r, busy_s;
  logic          accept_s;
  logic          tick_en_s;
  logic          phase_done_s;
  logic [DW-1:0] word_s;

  assign din_ready = ready_r;
  assign sclk      = sclk_r;
  assign sdi       = sdi_r;
  assign cs_n      = cs_n_r;
  assign busy      = busy_r;

  assign tick_en_s = (state_r == ST_LOW) || (state_r == ST_HIGH) || (state_r == ST_TAIL);

  ad5543_tick_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_tick_gen (
    .clk       (clk),
    .rst       (rst),
    .clr       (accept_s),
    .en        (tick_en_s),
    .phase_done(phase_done_s)
  );

  // Word formatting applied at accept
  always_comb begin
`ifdef AD5543_DRV_SIGNED_EN
    word_s = {~din[DW-1], din[DW-2:0]};
`else
    word_s = din;
`endif
  end

  // Next-state and next-output logic; the MSB goes to sdi at accept, the rest waits in shift_r
  always_comb begin
    state_s   = state_r;
    shift_s   = shift_r;
    bit_cnt_s = bit_cnt_r;
    gap_cnt_s = gap_cnt_r;
    sclk_s    = sclk_r;
    sdi_s     = sdi_r;
    cs_n_s    = cs_n_r;
    ready_s   = ready_r;
    busy_s    = busy_r;
    accept_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (din_valid && ready_r) begin
          accept_s  = 1'b1;
          state_s   = ST_LOW;
          shift_s   = word_s[DW-2:0];
          sdi_s     = word_s[DW-1];
          sclk_s    = 1'b0;
          cs_n_s    = 1'b0;
          ready_s   = 1'b0;
          busy_s    = 1'b1;
          bit_cnt_s = {BW{1'b0}};
          gap_cnt_s = {GW{1'b0}};
        end else begin
          ready_s = 1'b1;
          busy_s  = 1'b0;
        end
      end
      ST_LOW: begin
        if (phase_done_s) begin
          state_s   = ST_HIGH;
          sclk_s    = 1'b1;
          bit_cnt_s = bit_cnt_r + BW'(1'b1);
        end else begin
          sclk_s = 1'b0;
        end
      end
      ST_HIGH: begin
        if (phase_done_s) begin
          sclk_s = 1'b0;
          if (bit_cnt_r == BIT_LAST) begin
            state_s = ST_TAIL;
          end else begin
            // sdi only moves together with the falling sclk edge
            state_s = ST_LOW;
            sdi_s   = shift_r[DW-2];
            shift_s = shift_r << 1;
          end
        end else begin
          sclk_s = 1'b1;
        end
      end
      ST_TAIL: begin
        if (phase_done_s) begin
          state_s   = ST_GAP;
          cs_n_s    = 1'b1;
          gap_cnt_s = {GW{1'b0}};
        end else begin
          cs_n_s = 1'b0;
        end
      end
      ST_GAP: begin
        if (gap_cnt_r == GAP_LAST) begin
          state_s = ST_IDLE;
          ready_s = 1'b1;
          busy_s  = 1'b0;
        end else begin
          gap_cnt_s = gap_cnt_r + GW'(1'b1);
        end
      end
      default: begin
        state_s = ST_IDLE;
        sclk_s  = 1'b0;
        sdi_s   = 1'b0;
        cs_n_s  = 1'b1;
        ready_s = 1'b1;
        busy_s  = 1'b0;
      end
    endcase
  end

  // State and registered pin outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      shift_r   <= {(DW-1){1'b0}};
      bit_cnt_r <= {BW{1'b0}};
      gap_cnt_r <= {GW{1'b0}};
      sclk_r    <= 1'b0;
      sdi_r     <= 1'b0;
      cs_n_r    <= 1'b1;
      ready_r   <= 1'b1;
      busy_r    <= 1'b0;
    end else begin
      state_r   <= state_s;
      shift_r   <= shift_s;
      bit_cnt_r <= bit_cnt_s;
      gap_cnt_r <= gap_cnt_s;
      sclk_r    <= sclk_s;
      sdi_r     <= sdi_s;
      cs_n_r    <= cs_n_s;
      ready_r   <= ready_s;
      busy_r    <= busy_s;
    end
  end

endmodule
